word_narrow: RTL

Narrowing serializer that carries 32-bit words over a 16-bit datapath. It is the transmit-side counterpart of the 16→32 sign extender. A word whose upper half is pure sign extension of bit 15 goes out as a single compact 16-bit beat. Any other word goes out as two beats, low half first. The block sits between the 32-bit register/ALU side and the 16-bit immediate/memory bus, and a downstream sign extender plus assembler rebuilds the exact word.

---
 rtl/word_narrow_if.sv | 23 ++
 rtl/word_narrow.sv | 91 +++++++++
 2 files changed

// File: rtl/word_narrow_if.sv
// Stream bundle for the 32->16 narrowing serializer.
// slave is the serializer's view and master is the driving/consuming side.
interface word_narrow_if;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [15:0] OUT;
  logic        OUT_LAST;
  logic        OUT_FULL;
  logic [15:0] COMPACT_CNT;

  modport slave (
    input  IN_VALID, IN, OUT_READY,
    output IN_READY, OUT_VALID, OUT, OUT_LAST, OUT_FULL, COMPACT_CNT
  );

  modport master (
    output IN_VALID, IN, OUT_READY,
    input  IN_READY, OUT_VALID, OUT, OUT_LAST, OUT_FULL, COMPACT_CNT
  );
endinterface

// File: rtl/word_narrow.sv
// Sends 32-bit words over a 16-bit beat stream. A sign-extended word goes out
// as one beat; any other word goes out as two beats, low half first.
module word_narrow (
  input  logic          CLK,
  input  logic          RST,
  word_narrow_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] out_q,   out_d;
  logic        last_q,  last_d;
  logic        full_q,  full_d;
  logic [15:0] hi_q,    hi_d;
  logic [15:0] cnt_q,   cnt_d;

  logic out_valid;
  logic in_ready;
  logic accept;
  logic take;
  logic compact;

  assign out_valid = (state_q != ST_IDLE);
  // A last beat being taken frees the output register in the same edge.
  assign in_ready  = !out_valid || (bus.OUT_READY && last_q);
  assign accept    = bus.IN_VALID && in_ready;
  assign take      = out_valid && bus.OUT_READY;
  assign compact   = (bus.IN[31:16] == {16{bus.IN[15]}});

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    last_d  = last_q;
    full_d  = full_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;

    if (take && !full_q) begin
      cnt_d = cnt_q + 16'd1;
    end

    if (accept) begin
      state_d = ST_LOW;
      out_d   = bus.IN[15:0];
      last_d  = compact;
      full_d  = !compact;
      hi_d    = bus.IN[31:16];
    end else if (take) begin
      if (state_q == ST_LOW && full_q) begin
        state_d = ST_HIGH;
        out_d   = hi_q;
        last_d  = 1'b1;
      end else begin
        state_d = ST_IDLE;
        last_d  = 1'b0;
        full_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      out_q   <= 16'h0000;
      last_q  <= 1'b0;
      full_q  <= 1'b0;
      hi_q    <= 16'h0000;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      last_q  <= last_d;
      full_q  <= full_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.IN_READY    = in_ready;
  assign bus.OUT_VALID   = out_valid;
  assign bus.OUT         = out_q;
  assign bus.OUT_LAST    = last_q;
  assign bus.OUT_FULL    = full_q;
  assign bus.COMPACT_CNT = cnt_q;

endmodule
